// File: rtl/pool_pkg.sv
// Shared definitions for the conv/pool pipeline: pixel width, ceil-log2 helper
// and the pooling stage state encoding.
package pool_pkg;

    localparam int BITWIDTH = 8;

    // Ceil(log2(value)), never below 1 so it can size a vector directly.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer: holds the horizontal maxima of an even row until the
// matching odd row arrives. Combinational read, synchronous write.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int IDX_W = log2_ceil(DEPTH)
) (
    input  logic                clk_x5,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [BITWIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [BITWIDTH-1:0] rd_data
);

    logic [BITWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_x5 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/max_pool2_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered multi-map stream; each pooled
// pixel leaves with its MAX2 BRAM write address.
module max_pool2_stream
    import pool_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int MAPS   = 16,
    parameter int ADDR_W = log2_ceil(MAPS * (WIDTH / 2) * (HEIGHT / 2))
) (
    input  logic                clk_x5,
    input  logic                rstn,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Handshake: a beat moves on a rising clk_x5 edge where valid && ready are
    // both high; the producer holds valid and its payload stable until then.

    localparam int HALF_W = WIDTH / 2;
    localparam int HALF_H = HEIGHT / 2;
    localparam int XW     = log2_ceil(WIDTH);
    localparam int YW     = log2_ceil(HEIGHT);
    localparam int MW     = log2_ceil(MAPS);
    localparam int IDX_W  = log2_ceil(HALF_W);
    localparam logic [31:0] COLS = 32'(HALF_W * 2);
    localparam logic [31:0] ROWS = 32'(HALF_H * 2);

    pool_state_t state, state_nxt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [MW-1:0]       map;
    logic                in_done;
    logic                frame_start;
    logic [BITWIDTH-1:0] h_reg;
    logic [BITWIDTH-1:0] hmax;
    logic [BITWIDTH-1:0] result;
    logic [BITWIDTH-1:0] lbuf_rd;
    logic [ADDR_W-1:0]   load_addr;
    logic                take, in_col, in_row, lbuf_wr, load;
    logic                x_last, y_last, map_last;
    logic [IDX_W-1:0]    col_idx;

    assign take     = in_valid && in_ready;
    assign x_last   = (x == XW'(WIDTH - 1));
    assign y_last   = (y == YW'(HEIGHT - 1));
    assign map_last = (map == MW'(MAPS - 1));
    // A trailing odd column/row sits outside COLS/ROWS and is dropped here.
    assign in_col   = (32'(x) < COLS);
    assign in_row   = (32'(y) < ROWS);
    assign col_idx  = IDX_W'(x >> 1);

    assign hmax    = (in_data > h_reg) ? in_data : h_reg;
    assign result  = (lbuf_rd > hmax) ? lbuf_rd : hmax;
    assign lbuf_wr = take && x[0] && in_col && !y[0] && in_row;
    assign load    = take && x[0] && in_col && y[0] && in_row;

    assign load_addr = ADDR_W'(map) * ADDR_W'(HALF_W * HALF_H)
                     + ADDR_W'(y >> 1) * ADDR_W'(HALF_W)
                     + ADDR_W'(x >> 1);

    assign state_dbg = state;

    pool_line_buffer #(
        .DEPTH (HALF_W),
        .IDX_W (IDX_W)
    ) u_lbuf (
        .clk_x5  (clk_x5),
        .rstn    (rstn),
        .wr_en   (lbuf_wr),
        .wr_idx  (col_idx),
        .wr_data (hmax),
        .rd_idx  (col_idx),
        .rd_data (lbuf_rd)
    );

    always_ff @(posedge clk_x5 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // in_done marks that the last pixel of the last map has been taken; the
    // frame finishes once the output register has drained.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !in_done && (!out_valid || out_ready);
                if (in_done && (!out_valid || out_ready)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_x5 or negedge rstn) begin
        if (!rstn) begin
            x         <= '0;
            y         <= '0;
            map       <= '0;
            in_done   <= 1'b0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if (frame_start) begin
                x       <= '0;
                y       <= '0;
                map     <= '0;
                in_done <= 1'b0;
            end else if (take) begin
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        y <= '0;
                        if (map_last) begin
                            map     <= '0;
                            in_done <= 1'b1;
                        end else begin
                            map <= map + 1'b1;
                        end
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end

            if (take && !x[0] && in_col) h_reg <= in_data;

            // Loading and draining in the same cycle leaves out_valid high.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_addr  <= load_addr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_pool2_stream.sv
// Scoreboard bench for max_pool2_stream on a 5x5x3 geometry (odd width and
// height), with directed frames, stalls, stray starts and a mid-frame reset.
module tb_max_pool2_stream;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int M    = 3;
    localparam int HW   = W / 2;
    localparam int HH   = H / 2;
    localparam int NPIX = W * H * M;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic          clk_x5 = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, busy, done;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [1:0]    state_dbg;

    always #5 clk_x5 = ~clk_x5;

    max_pool2_stream #(
        .WIDTH  (W),
        .HEIGHT (H),
        .MAPS   (M),
        .ADDR_W (AW)
    ) dut (
        .clk_x5    (clk_x5),
        .rstn      (rstn),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    int              checks = 0;
    int              failures = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]   frame [NPIX];
    int              ready_pct = 100;
    bit              abort_drive = 1'b0;
    bit              drive_busy = 1'b0;
    int              done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Downstream readiness
    initial begin
        forever begin
            @(posedge clk_x5);
            #1;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk_x5);
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("out_addr", 32'(out_addr), 32'(e[AW+DW-1:DW]));
                    check("out_data", 32'(out_data), 32'(e[DW-1:0]));
                end
            end
            if (rstn && done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 0);
                check("queue_drained_at_done", 32'(exp_q.size()), 0);
            end
        end
    end

    function automatic int pix_idx(input int m, input int yy, input int xx);
        return m * W * H + yy * W + xx;
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < NPIX; i++) begin
            case (pat)
                0: frame[i] = 8'(i);
                1: frame[i] = 8'(200 - 2 * i);
                2: frame[i] = 8'($urandom_range(0, 255));
                default: begin
                    if (i < W * H)          frame[i] = 8'd0;
                    else if (i < 2 * W * H) frame[i] = 8'd77;
                    else                    frame[i] = (i % 7 == 3) ? 8'd255 : 8'(i % 2);
                end
            endcase
        end
    endtask

    // Ramp frame: window top-left is 25m+10py+2px, so its max is that plus 6.
    task automatic push_ramp_expected();
        for (int m = 0; m < M; m++)
            for (int py = 0; py < HH; py++)
                for (int px = 0; px < HW; px++)
                    exp_q.push_back({AW'(m * HW * HH + py * HW + px),
                                     DW'(25 * m + 10 * py + 2 * px + 6)});
    endtask

    task automatic push_model();
        logic [DW-1:0] mx;
        logic [DW-1:0] v;
        for (int m = 0; m < M; m++)
            for (int py = 0; py < HH; py++)
                for (int px = 0; px < HW; px++) begin
                    mx = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = frame[pix_idx(m, 2 * py + dy, 2 * px + dx)];
                            if (v > mx) mx = v;
                        end
                    exp_q.push_back({AW'(m * HW * HH + py * HW + px), mx});
                end
    endtask

    task automatic drive_frame(input int vpct);
        bit acc;
        int tries;
        drive_busy = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                @(posedge clk_x5);
                #1;
                if (abort_drive) begin
                    in_valid = 1'b0;
                    drive_busy = 1'b0;
                    return;
                end
                in_valid = ($urandom_range(0, 99) < vpct);
                in_data = frame[i];
                @(negedge clk_x5);
                acc = in_valid && in_ready;
                tries++;
                if (!acc && tries > 400) begin
                    fail_now("input_accept_timeout");
                    in_valid = 1'b0;
                    drive_busy = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk_x5);
        #1;
        in_valid = 1'b0;
        drive_busy = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk_x5);
        #1;
        start = 1'b1;
        @(posedge clk_x5);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_driver();
        int n;
        n = 0;
        while (drive_busy && n < 300) begin
            @(posedge clk_x5);
            n++;
        end
        if (drive_busy) fail_now("driver_stuck");
    endtask

    task automatic wait_done(input bit start_in_done);
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk_x5);
            n++;
            if (done) begin
                seen = 1'b1;
                if (start_in_done) start = 1'b1;
            end
        end
        if (!seen) fail_now("done_timeout");
        if (start_in_done) begin
            @(posedge clk_x5);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic run_frame(input int pat, input int vpct, input int rpct, input bit stall,
                             input bit start_in_run, input bit start_in_done);
        int d0;
        int n;
        logic [DW-1:0] first_val;
        fill(pat);
        if (pat == 0) push_ramp_expected();
        else          push_model();
        first_val = exp_q[0][DW-1:0];
        ready_pct = stall ? 0 : rpct;
        d0 = done_cnt;
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        fork
            drive_frame(vpct);
        join_none
        if (stall) begin
            n = 0;
            while (!out_valid && n < 500) begin
                @(negedge clk_x5);
                n++;
            end
            if (!out_valid) fail_now("first_output_timeout");
            repeat (5) begin
                @(negedge clk_x5);
                check("stall_in_ready", 32'(in_ready), 0);
                check("stall_out_valid", 32'(out_valid), 1);
                check("stall_out_data_held", 32'(out_data), 32'(first_val));
            end
            ready_pct = rpct;
        end
        if (start_in_run) begin
            repeat (20) @(posedge clk_x5);
            #1;
            start = 1'b1;
            @(posedge clk_x5);
            #1;
            start = 1'b0;
        end
        wait_done(start_in_done);
        wait_driver();
        repeat (5) @(negedge clk_x5);
        check("one_done_per_frame", 32'(done_cnt - d0), 1);
        check("idle_after_frame", 32'(state_dbg), 0);
        check("busy_low_after_frame", 32'(busy), 0);
        check("all_outputs_seen", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_addr"}, 32'(out_addr), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_state"}, 32'(state_dbg), 0);
    endtask

    initial begin
        int d0;
        int n;
        #12;
        check_reset_outputs("reset");
        @(posedge clk_x5);
        #1;
        rstn = 1'b1;
        repeat (2) @(negedge clk_x5);
        check("idle_ignores_no_start", 32'(state_dbg), 0);

        run_frame(0, 100, 100, 1'b0, 1'b0, 1'b0);
        run_frame(1, 100, 100, 1'b1, 1'b0, 1'b0);
        run_frame(2, 60, 50, 1'b0, 1'b1, 1'b1);
        run_frame(3, 80, 70, 1'b0, 1'b0, 1'b0);

        // Abort a frame partway into map 1.
        fill(2);
        push_model();
        ready_pct = 70;
        pulse_start();
        fork
            drive_frame(80);
        join_none
        n = 0;
        while (!(out_valid && out_addr == AW'(5)) && n < 2000) begin
            @(negedge clk_x5);
            n++;
        end
        if (n >= 2000) fail_now("mid_frame_timeout");
        @(posedge clk_x5);
        #1;
        rstn = 1'b0;
        abort_drive = 1'b1;
        d0 = done_cnt;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (3) @(posedge clk_x5);
        #1;
        rstn = 1'b1;
        wait_driver();
        abort_drive = 1'b0;
        repeat (10) @(negedge clk_x5);
        check("no_done_after_abort", 32'(done_cnt - d0), 0);
        check("idle_after_abort", 32'(state_dbg), 0);

        run_frame(2, 70, 60, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
